tc_register_file: RTL and testbench



---
 rtl/tc_pkg.sv | 13 +
 rtl/tc_regfile_read_port.sv | 65 ++++++
 rtl/tc_register_file.sv | 106 ++++++++++
 tb/tb_tc_register_file.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the tc_register_file family: default sizes and the
// address-width helper used to derive port widths.
package tc_pkg;

  localparam int TC_DEFAULT_BIT_WIDTH = 8;
  localparam int TC_DEFAULT_NUM_REGS  = 8;

  // Address width for n entries, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tc_regfile_read_port.sv
// One gated read port of tc_register_file: address range check, zero-register
// mask, optional write-first bypass and the registered, zero-when-idle output.
// Optional feature macro: TC_REGFILE_BYPASS_EN (write-first bypass).
module tc_regfile_read_port
  import tc_pkg::*;
#(
  parameter int BIT_WIDTH  = TC_DEFAULT_BIT_WIDTH,
  parameter int NUM_REGS   = TC_DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = clog2_min1(NUM_REGS),
  parameter int ZERO_REG   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [NUM_REGS*BIT_WIDTH-1:0] entries,
  input  logic                          wr_ok,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [BIT_WIDTH-1:0]          wdata,
  output logic [BIT_WIDTH-1:0]          rdata
);

  logic                 raddr_ok;
  logic                 raddr_zero;
  logic [BIT_WIDTH-1:0] entry_sel;
  logic [BIT_WIDTH-1:0] rdata_d;
  logic [BIT_WIDTH-1:0] rdata_q;

  // Select the addressed entry and decide what the output register takes next.
  always_comb begin
    raddr_ok   = int'(raddr) < NUM_REGS;
    raddr_zero = (ZERO_REG != 0) && (raddr == '0);
    entry_sel  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(raddr) == i) begin
        entry_sel = entries[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
    rdata_d = '0;
    if (!reset && load && raddr_ok && !raddr_zero) begin
      rdata_d = entry_sel;
`ifdef TC_REGFILE_BYPASS_EN
      // wr_ok already excludes out-of-range and zero-register writes.
      if (wr_ok && (waddr == raddr)) begin
        rdata_d = wdata;
      end
`endif
    end
  end

`ifdef TC_REGFILE_BYPASS_EN
`else
  // Write-side inputs only feed the bypass mux.
  logic unused_bypass;
  assign unused_bypass = ^{wr_ok, waddr, wdata};
`endif

  // Output register; a cleared next value covers both reset and load low.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tc_register_file.sv
// General-purpose register bank: NUM_REGS x BIT_WIDTH storage, one write port,
// two independent gated read ports with registered zero-when-idle outputs,
// and a one-cycle flag for writes to nonexistent entries.
// Optional feature macro: TC_REGFILE_BYPASS_EN (write-first read bypass).
module tc_register_file
  import tc_pkg::*;
#(
  parameter int BIT_WIDTH  = TC_DEFAULT_BIT_WIDTH,
  parameter int NUM_REGS   = TC_DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = clog2_min1(NUM_REGS),
  parameter int ZERO_REG   = 0,
  parameter int UUID       = 0,
  parameter     NAME       = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  save,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BIT_WIDTH-1:0]  in,
  input  logic                  load_a,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [BIT_WIDTH-1:0]  out_a,
  input  logic                  load_b,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [BIT_WIDTH-1:0]  out_b,
  output logic                  wr_err
);

  logic [BIT_WIDTH-1:0]          mem_q [NUM_REGS];
  logic [BIT_WIDTH-1:0]          mem_d [NUM_REGS];
  logic                          wr_err_q;
  logic                          wr_err_d;
  logic                          waddr_ok;
  logic                          wr_ok;
  logic [NUM_REGS*BIT_WIDTH-1:0] entries;

  // Netlist identity travels with the instance but drives no logic.
  logic unused_meta;
  assign unused_meta = ^{UUID, NAME};

  // Write decode and next storage state; reset wins over any concurrent write.
  always_comb begin
    waddr_ok = int'(waddr) < NUM_REGS;
    wr_ok    = save && waddr_ok && !((ZERO_REG != 0) && (waddr == '0));
    wr_err_d = reset ? 1'b0 : (save && !waddr_ok);
    mem_d    = mem_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        mem_d[i] = '0;
      end else if (wr_ok && (int'(waddr) == i)) begin
        mem_d[i] = in;
      end
    end
  end

  // Storage array and write-error flag.
  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_err_q <= wr_err_d;
  end

  // Flatten the array so each read port sees the current (pre-write) contents.
  always_comb begin
    entries = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      entries[i*BIT_WIDTH +: BIT_WIDTH] = mem_q[i];
    end
  end

  tc_regfile_read_port #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port_a (
    .clk    (clk),
    .reset  (reset),
    .load   (load_a),
    .raddr  (raddr_a),
    .entries(entries),
    .wr_ok  (wr_ok),
    .waddr  (waddr),
    .wdata  (in),
    .rdata  (out_a)
  );

  tc_regfile_read_port #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port_b (
    .clk    (clk),
    .reset  (reset),
    .load   (load_b),
    .raddr  (raddr_b),
    .entries(entries),
    .wr_ok  (wr_ok),
    .waddr  (waddr),
    .wdata  (in),
    .rdata  (out_b)
  );

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_tc_register_file.sv
// Scoreboard bench for tc_register_file: a default 8x8 instance and a
// 6x16 instance with the zero register enabled.
module tb_tc_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TC_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        reset;

  logic        s0_save, s0_load_a, s0_load_b, s0_wr_err;
  logic [2:0]  s0_waddr, s0_raddr_a, s0_raddr_b;
  logic [7:0]  s0_in, s0_out_a, s0_out_b;

  logic        s1_save, s1_load_a, s1_load_b, s1_wr_err;
  logic [2:0]  s1_waddr, s1_raddr_a, s1_raddr_b;
  logic [15:0] s1_in, s1_out_a, s1_out_b;

  tc_register_file #(
    .BIT_WIDTH(8), .NUM_REGS(8), .ZERO_REG(0), .UUID(1), .NAME("rf0")
  ) dut0 (
    .clk(clk), .reset(reset), .save(s0_save), .waddr(s0_waddr), .in(s0_in),
    .load_a(s0_load_a), .raddr_a(s0_raddr_a), .out_a(s0_out_a),
    .load_b(s0_load_b), .raddr_b(s0_raddr_b), .out_b(s0_out_b),
    .wr_err(s0_wr_err)
  );

  tc_register_file #(
    .BIT_WIDTH(16), .NUM_REGS(6), .ZERO_REG(1), .UUID(2), .NAME("rf1")
  ) dut1 (
    .clk(clk), .reset(reset), .save(s1_save), .waddr(s1_waddr), .in(s1_in),
    .load_a(s1_load_a), .raddr_a(s1_raddr_a), .out_a(s1_out_a),
    .load_b(s1_load_b), .raddr_b(s1_raddr_b), .out_b(s1_out_b),
    .wr_err(s1_wr_err)
  );

  typedef struct {
    int          dut;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ee;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Values written into dut1 entries 1..5.
  function automatic logic [15:0] fill_val(input int i);
    return 16'(16'h1000 + i * 16'h0111);
  endfunction

  // One cycle of stimulus on one instance; the record holds the outputs
  // expected right after this cycle's rising edge.
  task automatic drive(input int d, input bit rst, input bit sv,
                       input logic [2:0] wa, input logic [15:0] wd,
                       input bit la, input logic [2:0] ra,
                       input bit lb, input logic [2:0] rb,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input bit ee, input string tag);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    s0_save   = 1'b0; s0_load_a = 1'b0; s0_load_b = 1'b0;
    s1_save   = 1'b0; s1_load_a = 1'b0; s1_load_b = 1'b0;
    if (d == 0) begin
      s0_save = sv; s0_waddr = wa; s0_in = wd[7:0];
      s0_load_a = la; s0_raddr_a = ra; s0_load_b = lb; s0_raddr_b = rb;
    end else begin
      s1_save = sv; s1_waddr = wa; s1_in = wd;
      s1_load_a = la; s1_raddr_a = ra; s1_load_b = lb; s1_raddr_b = rb;
    end
    e.dut = d; e.ea = ea; e.eb = eb; e.ee = ee; e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the outputs to the oldest record.
  initial begin
    exp_t        e;
    logic [15:0] aa, ab;
    logic        ae;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.dut == 0) begin
          aa = {8'h00, s0_out_a}; ab = {8'h00, s0_out_b}; ae = s0_wr_err;
        end else begin
          aa = s1_out_a; ab = s1_out_b; ae = s1_wr_err;
        end
        chk({e.tag, ".out_a"}, aa, e.ea);
        chk({e.tag, ".out_b"}, ab, e.eb);
        chk({e.tag, ".wr_err"}, {15'h0, ae}, {15'h0, e.ee});
      end
    end
  end

  initial begin
    reset = 1'b1;
    s0_save = 0; s0_waddr = 0; s0_in = 0; s0_load_a = 0; s0_raddr_a = 0; s0_load_b = 0; s0_raddr_b = 0;
    s1_save = 0; s1_waddr = 0; s1_in = 0; s1_load_a = 0; s1_raddr_a = 0; s1_load_b = 0; s1_raddr_b = 0;

    // Reset held two cycles, with writes and loads that must be ignored.
    drive(0, 1, 1, 3'd1, 16'h0055, 1, 3'd1, 1, 3'd2, 16'h0, 16'h0, 0, "reset_hold0");
    drive(0, 1, 1, 3'd1, 16'h0055, 1, 3'd1, 1, 3'd2, 16'h0, 16'h0, 0, "reset_hold1");
    for (int i = 0; i < 8; i++)
      drive(0, 0, 0, 3'd0, 16'h0, 1, 3'(i), 1, 3'(7 - i), 16'h0, 16'h0, 0, "reset_sweep");

    // Basic write/read and gated output.
    drive(0, 0, 1, 3'd3, 16'h00A5, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "write3");
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd3, 1, 3'd2, 16'h00A5, 16'h0, 0, "read3");
    drive(0, 0, 0, 3'd0, 16'h0, 0, 3'd3, 0, 3'd3, 16'h0, 16'h0, 0, "load_low");

    // Dual read with read-during-write on the same address.
    drive(0, 0, 1, 3'd5, 16'h0011, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "write5");
    drive(0, 0, 1, 3'd5, 16'h0022, 1, 3'd5, 1, 3'd5,
          BYP ? 16'h0022 : 16'h0011, BYP ? 16'h0022 : 16'h0011, 0, "rdw5");
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd5, 1, 3'd5, 16'h0022, 16'h0022, 0, "read5_new");
    drive(0, 0, 1, 3'd6, 16'h0066, 1, 3'd6, 1, 3'd3,
          BYP ? 16'h0066 : 16'h0000, 16'h00A5, 0, "rdw_one_port");
    drive(0, 0, 1, 3'd7, 16'h0077, 1, 3'd6, 0, 3'd0, 16'h0066, 16'h0, 0, "write7");
    drive(0, 0, 0, 3'd0, 16'h0, 0, 3'd0, 1, 3'd7, 16'h0, 16'h0077, 0, "read7");

    // Reset in the middle of traffic discards the concurrent write.
    drive(0, 0, 1, 3'd2, 16'h000F, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "write2");
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd2, 0, 3'd0, 16'h000F, 16'h0, 0, "read2");
    drive(0, 1, 1, 3'd2, 16'h00F0, 1, 3'd2, 1, 3'd3, 16'h0, 16'h0, 0, "mid_reset");
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd2, 1, 3'd3, 16'h0, 16'h0, 0, "post_reset");
    drive(0, 0, 0, 3'd0, 16'h0, 1, 3'd5, 1, 3'd7, 16'h0, 16'h0, 0, "post_reset2");

    // Zero register on the 6x16 instance.
    drive(1, 0, 1, 3'd0, 16'h00FF, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "zr_write");
    drive(1, 0, 0, 3'd0, 16'h0, 1, 3'd0, 1, 3'd0, 16'h0, 16'h0, 0, "zr_read");
    drive(1, 0, 1, 3'd0, 16'hBEEF, 1, 3'd0, 1, 3'd0, 16'h0, 16'h0, 0, "zr_rdw");
    for (int i = 1; i < 6; i++)
      drive(1, 0, 1, 3'(i), fill_val(i), 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "fill");

    // Out-of-range writes on a non-power-of-two bank.
    drive(1, 0, 1, 3'd7, 16'h1234, 1, 3'd7, 1, 3'd5, 16'h0, fill_val(5), 1, "oor_write7");
    drive(1, 0, 0, 3'd0, 16'h0, 1, 3'd7, 1, 3'd6, 16'h0, 16'h0, 0, "oor_clear");
    for (int i = 0; i < 6; i++)
      drive(1, 0, 0, 3'd0, 16'h0, 1, 3'(i), 1, 3'(5 - i),
            (i == 0) ? 16'h0 : fill_val(i), (i == 5) ? 16'h0 : fill_val(5 - i),
            0, "oor_unchanged");
    drive(1, 0, 1, 3'd6, 16'hAAAA, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 1, "oor_write6");
    drive(1, 0, 1, 3'd4, 16'h4444, 0, 3'd0, 0, 3'd0, 16'h0, 16'h0, 0, "inrange_write4");
    drive(1, 0, 0, 3'd0, 16'h0, 1, 3'd4, 1, 3'd1, 16'h4444, fill_val(1), 0, "read4");

    // Idle both instances and let the monitor drain the scoreboard.
    @(negedge clk);
    s0_save = 0; s0_load_a = 0; s0_load_b = 0;
    s1_save = 0; s1_load_a = 0; s1_load_b = 0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
